axi_write_arbiter: RTL and testbench

AXI_WRITE_ARBITER -- requirements
Module: axi_write_arbiter

---
 rtl/axi_write_arbiter.sv | 164 ++++++++++++++++
 tb/tb_axi_write_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_arbiter.sv
// Two-requester AXI4 single-beat write arbiter with one outstanding write.
// Define WRITE_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed priority (req0 first).
module axi_write_arbiter #(
   parameter logic [3:0] BASE_ID = 4'b0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_we,
   input  logic [31:0] req0_addr,
   input  logic [31:0] req0_data,
   input  logic [3:0]  req0_sel,
   output logic        req0_done,
   input  logic        req1_we,
   input  logic [31:0] req1_addr,
   input  logic [31:0] req1_data,
   input  logic [3:0]  req1_sel,
   output logic        req1_done,
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [3:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic [1:0]  awlock,
   output logic [3:0]  awcache,
   output logic [2:0]  awprot,
   output logic        awvalid,
   input  logic        awready,
   output logic [3:0]  wid,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic [3:0]  bid,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);

   typedef enum logic [1:0] {IDLE, ADDR_DATA, RESP} state_t;

   state_t      state_q, state_d;
   logic        grant_q, grant_d;
   logic        awValid_q, awValid_d;
   logic        wValid_q, wValid_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [3:0]  sel_q, sel_d;
   logic        anyReq;
   logic        winner;
   logic        awDone;
   logic        wDone;
   logic        unusedBInputs;

   assign anyReq        = req0_we | req1_we;
   assign awDone        = ~awValid_q | awready;
   assign wDone         = ~wValid_q | wready;
   assign unusedBInputs = ^{bid, bresp};

`ifdef WRITE_ARB_ROUND_ROBIN_EN
   logic lastGrant_q, lastGrant_d;

   // On contention the requester that did not win last time goes next.
   assign winner = (req0_we & req1_we) ? ~lastGrant_q : req1_we;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lastGrant_q <= 1'b1;
      end else begin
         lastGrant_q <= lastGrant_d;
      end
   end

   always_comb begin
      lastGrant_d = lastGrant_q;
      if (state_q == IDLE && anyReq) begin
         lastGrant_d = winner;
      end
   end
`else
   assign winner = ~req0_we;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         grant_q   <= 1'b0;
         awValid_q <= 1'b0;
         wValid_q  <= 1'b0;
         addr_q    <= 32'h0;
         data_q    <= 32'h0;
         sel_q     <= 4'h0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         awValid_q <= awValid_d;
         wValid_q  <= wValid_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         sel_q     <= sel_d;
      end
   end

   // AW and W retire independently; the response phase starts once both have.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      awValid_d = awValid_q;
      wValid_d  = wValid_q;
      addr_d    = addr_q;
      data_d    = data_q;
      sel_d     = sel_q;
      case (state_q)
         IDLE: begin
            if (anyReq) begin
               state_d   = ADDR_DATA;
               grant_d   = winner;
               awValid_d = 1'b1;
               wValid_d  = 1'b1;
               addr_d    = winner ? req1_addr : req0_addr;
               data_d    = winner ? req1_data : req0_data;
               sel_d     = winner ? req1_sel  : req0_sel;
            end
         end
         ADDR_DATA: begin
            if (awValid_q && awready) begin
               awValid_d = 1'b0;
            end
            if (wValid_q && wready) begin
               wValid_d = 1'b0;
            end
            if (awDone && wDone) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (bvalid) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bready    = (state_q == RESP);
   assign req0_done = (state_q == RESP) & bvalid & ~grant_q;
   assign req1_done = (state_q == RESP) & bvalid & grant_q;

   assign awid    = BASE_ID + {3'b000, grant_q};
   assign wid     = BASE_ID + {3'b000, grant_q};
   assign awaddr  = addr_q;
   assign wdata   = data_q;
   assign wstrb   = sel_q;
   assign awvalid = awValid_q;
   assign wvalid  = wValid_q;
   assign awlen   = 4'b0000;
   assign awsize  = 3'b010;
   assign awburst = 2'b00;
   assign awlock  = 2'b00;
   assign awcache = 4'b0000;
   assign awprot  = 3'b000;
   assign wlast   = 1'b1;

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Self-checking bench for axi_write_arbiter: transaction-level model compared every cycle plus directed literal checks.
module tb_axi_write_arbiter;

   localparam logic [3:0] BASE_ID = 4'b0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_we, req1_we;
   logic [31:0] req0_addr, req1_addr, req0_data, req1_data;
   logic [3:0]  req0_sel, req1_sel;
   logic        req0_done, req1_done;
   logic [3:0]  awid, wid, awlen, awcache, wstrb, bid;
   logic [31:0] awaddr, wdata;
   logic [2:0]  awsize, awprot;
   logic [1:0]  awburst, awlock, bresp;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

   int checks = 0;
   int failures = 0;

   axi_write_arbiter #(.BASE_ID(BASE_ID)) dut (
      .clk(clk), .reset(reset),
      .req0_we(req0_we), .req0_addr(req0_addr), .req0_data(req0_data), .req0_sel(req0_sel), .req0_done(req0_done),
      .req1_we(req1_we), .req1_addr(req1_addr), .req1_data(req1_data), .req1_sel(req1_sel), .req1_done(req1_done),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
      .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input bit we0, input bit we1, input bit awr, input bit wr, input bit bv);
      req0_we = we0;
      req1_we = we1;
      awready = awr;
      wready  = wr;
      bvalid  = bv;
   endtask

   // Transaction-level model: a write is outstanding from grant until its response is accepted.
   bit          mBusy = 0, mAwOpen = 0, mWOpen = 0, mInResp = 0, mGrant = 0, mLast = 1;
   logic [31:0] mAddr = 0, mData = 0;
   logic [3:0]  mSel = 0;
   int          mGrants[$];

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mBusy = 0; mAwOpen = 0; mWOpen = 0; mInResp = 0; mGrant = 0; mLast = 1;
         mAddr = 0; mData = 0; mSel = 0;
      end else if (!mBusy) begin
         if (req0_we || req1_we) begin
`ifdef WRITE_ARB_ROUND_ROBIN_EN
            if (req0_we && req1_we) mGrant = (mLast == 1'b0);
            else                    mGrant = req1_we;
`else
            mGrant = req0_we ? 1'b0 : 1'b1;
`endif
            mLast   = mGrant;
            mAddr   = mGrant ? req1_addr : req0_addr;
            mData   = mGrant ? req1_data : req0_data;
            mSel    = mGrant ? req1_sel  : req0_sel;
            mBusy   = 1; mAwOpen = 1; mWOpen = 1; mInResp = 0;
            mGrants.push_back(int'(mGrant));
         end
      end else if (!mInResp) begin
         if (mAwOpen && awready) mAwOpen = 0;
         if (mWOpen && wready)   mWOpen = 0;
         if (!mAwOpen && !mWOpen) mInResp = 1;
      end else if (bvalid) begin
         mBusy = 0; mInResp = 0;
      end
   end

   int dutDone[$];
   int done0Count = 0;
   int done1Count = 0;

   // Mid-cycle comparison of every output against the model, plus completion logging.
   always @(negedge clk) begin
      checkOutput("awvalid", 64'(awvalid), 64'(mAwOpen));
      checkOutput("wvalid", 64'(wvalid), 64'(mWOpen));
      checkOutput("bready", 64'(bready), 64'(mInResp));
      checkOutput("req0_done", 64'(req0_done), 64'(mInResp && bvalid && !mGrant));
      checkOutput("req1_done", 64'(req1_done), 64'(mInResp && bvalid && mGrant));
      checkOutput("awid", 64'(awid), 64'(BASE_ID + {3'b000, mGrant}));
      checkOutput("wid", 64'(wid), 64'(BASE_ID + {3'b000, mGrant}));
      checkOutput("awaddr", 64'(awaddr), 64'(mAddr));
      checkOutput("wdata", 64'(wdata), 64'(mData));
      checkOutput("wstrb", 64'(wstrb), 64'(mSel));
      checkOutput("constants", 64'({awlen, awsize, awburst, awlock, awcache, awprot, wlast}),
                  64'({4'b0000, 3'b010, 2'b00, 2'b00, 4'b0000, 3'b000, 1'b1}));
      if (req0_done) begin dutDone.push_back(0); done0Count++; end
      if (req1_done) begin dutDone.push_back(1); done1Count++; end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int expS4[4];
      int expGrants[11];
      int v;
`ifdef WRITE_ARB_ROUND_ROBIN_EN
      expS4     = '{0, 1, 0, 1};
      expGrants = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1};
`else
      expS4     = '{0, 0, 0, 0};
      expGrants = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1};
`endif
      req0_addr = 0; req0_data = 0; req0_sel = 0;
      req1_addr = 0; req1_data = 0; req1_sel = 0;
      bid = 4'h5; bresp = 2'b10;
      applyStimulus(0, 0, 0, 0, 0);
      #1 reset = 1'b0;
      #1;
      checkOutput("rst_awvalid", 64'(awvalid), 64'h0);
      checkOutput("rst_wvalid", 64'(wvalid), 64'h0);
      checkOutput("rst_bready", 64'(bready), 64'h0);
      checkOutput("rst_done", 64'({req0_done, req1_done}), 64'h0);
      checkOutput("rst_awaddr", 64'(awaddr), 64'h0);
      tick(); tick();
      reset = 1'b1;

      // Single write with immediate handshakes
      req0_addr = 32'h1000_0004; req0_data = 32'hDEAD_BEEF; req0_sel = 4'hF;
      applyStimulus(1, 0, 1, 1, 0);
      tick(); #1;
      checkOutput("s1_awvalid", 64'(awvalid), 64'h1);
      checkOutput("s1_awaddr", 64'(awaddr), 64'h1000_0004);
      checkOutput("s1_wdata", 64'(wdata), 64'hDEAD_BEEF);
      checkOutput("s1_awid", 64'(awid), 64'h0);
      checkOutput("s1_wstrb", 64'(wstrb), 64'hF);
      tick();
      checkOutput("s1_bready", 64'(bready), 64'h1);
      applyStimulus(0, 0, 1, 1, 1); #1;
      checkOutput("s1_done", 64'(req0_done), 64'h1);

      // Split handshakes: W first, AW three cycles later
      tick();
      req1_addr = 32'h2000_0010; req1_data = 32'h1234_5678; req1_sel = 4'h3;
      applyStimulus(0, 1, 0, 1, 0); #1;
      checkOutput("s1_done_low", 64'(req0_done), 64'h0);
      checkOutput("s1_bready_low", 64'(bready), 64'h0);
      tick(); #1;
      checkOutput("s2_valids", 64'({awvalid, wvalid}), 64'h3);
      checkOutput("s2_awid", 64'(awid), 64'h1);
      tick(); #1;
      checkOutput("s2_valids_split", 64'({awvalid, wvalid}), 64'h2);
      checkOutput("s2_bready_c1", 64'(bready), 64'h0);
      tick(); tick(); #1;
      checkOutput("s2_awvalid_held", 64'(awvalid), 64'h1);
      checkOutput("s2_bready_c3", 64'(bready), 64'h0);
      applyStimulus(0, 1, 1, 0, 0);
      tick(); #1;
      checkOutput("s2_awvalid_clr", 64'(awvalid), 64'h0);
      checkOutput("s2_bready_hi", 64'(bready), 64'h1);
      applyStimulus(0, 0, 0, 0, 1); #1;
      checkOutput("s2_done", 64'(req1_done), 64'h1);
      tick();

      // Response backpressure with a competing request waiting
      req0_addr = 32'h3000_0000; req0_data = 32'hA5A5_0001; req0_sel = 4'h1;
      applyStimulus(1, 0, 1, 1, 0);
      tick(); tick();
      req1_addr = 32'h4000_0008; req1_data = 32'h0BAD_F00D; req1_sel = 4'hC;
      applyStimulus(1, 1, 1, 1, 0);
      repeat (10) begin
         #1;
         checkOutput("s3_bready_wait", 64'(bready), 64'h1);
         checkOutput("s3_no_done", 64'({req0_done, req1_done}), 64'h0);
         checkOutput("s3_no_grant", 64'(awvalid), 64'h0);
         tick();
      end
      applyStimulus(0, 1, 1, 1, 1); #1;
      checkOutput("s3_done0", 64'(req0_done), 64'h1);
      tick();
      applyStimulus(0, 1, 1, 1, 0);
      tick(); #1;
      checkOutput("s3_awid1", 64'(awid), 64'h1);
      checkOutput("s3_awaddr1", 64'(awaddr), 64'h4000_0008);
      tick();
      applyStimulus(0, 0, 1, 1, 1); #1;
      checkOutput("s3_done1", 64'(req1_done), 64'h1);
      tick();

      // Continuous contention
      dutDone.delete();
      applyStimulus(1, 1, 1, 1, 1);
      repeat (12) tick();
      applyStimulus(0, 0, 0, 0, 0);
      repeat (3) tick();
      checkOutput("s4_count", 64'(dutDone.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         v = (i < dutDone.size()) ? dutDone[i] : 99;
         checkOutput($sformatf("s4_grant%0d", i), 64'(v), 64'(expS4[i]));
      end

      // Request dropped right after grant still completes
      applyStimulus(1, 0, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 1, 1, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 1); #1;
      checkOutput("s5_done", 64'(req0_done), 64'h1);
      tick();
      applyStimulus(1, 0, 0, 0, 0);

      // Reset in the middle of an address/data phase
      tick(); #1;
      checkOutput("s6_awvalid", 64'(awvalid), 64'h1);
      applyStimulus(0, 1, 0, 0, 0);
      reset = 1'b0; #1;
      checkOutput("s6_rst_valids", 64'({awvalid, wvalid}), 64'h0);
      checkOutput("s6_rst_awaddr", 64'(awaddr), 64'h0);
      tick(); tick();
      reset = 1'b1;
      tick(); #1;
      checkOutput("s6_awvalid1", 64'(awvalid), 64'h1);
      checkOutput("s6_awid1", 64'(awid), 64'h1);
      applyStimulus(0, 1, 1, 1, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 1); #1;
      checkOutput("s6_done1", 64'(req1_done), 64'h1);
      tick();
      applyStimulus(0, 0, 0, 0, 0);
      tick();

`ifdef WRITE_ARB_ROUND_ROBIN_EN
      checkOutput("total_done0", 64'(done0Count), 64'd5);
      checkOutput("total_done1", 64'(done1Count), 64'd5);
`else
      checkOutput("total_done0", 64'(done0Count), 64'd7);
      checkOutput("total_done1", 64'(done1Count), 64'd3);
`endif
      checkOutput("model_grant_count", 64'(mGrants.size()), 64'd11);
      for (int i = 0; i < 11; i++) begin
         v = (i < mGrants.size()) ? mGrants[i] : 99;
         checkOutput($sformatf("model_grant%0d", i), 64'(v), 64'(expGrants[i]));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
